// File: rtl/alu_bus_master_if.sv
// Command, response and slave-bus signals of the ALUwMul bus master.
// The master modport is the initiator side; the slave modport is the controller/slave-register side.
interface alu_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        M_sel;
  logic        M_wr;
  logic [7:0]  M_addr;
  logic [31:0] M_dout;
  logic [31:0] M_din;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, M_din,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, M_sel, M_wr, M_addr, M_dout
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, M_din,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, M_sel, M_wr, M_addr, M_dout
  );
endinterface

// File: rtl/alu_bus_master.sv
// Bus initiator for the ALUwMul slave: writes A/B/op, starts, polls done,
// reads the 64-bit result, clears the slave and returns the result.
module alu_bus_master #(
  parameter int POLL_TIMEOUT = 1024,
  parameter int TO_W         = 11
) (
  input  logic              clk,
  input  logic              reset,
  alu_bus_master_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, WR_A, WR_B, WR_OP, WR_GO, RD_ST, ST_W,
    RD_LO, LO_W, RD_HI, HI_W, WR_CLR, RSP
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(POLL_TIMEOUT - 1);

  state_t          state_r, state_s;
  logic [31:0]     b_r;
  logic [3:0]      op_r;
  logic [TO_W-1:0] cnt_r, cnt_s;
  logic [63:0]     data_r, data_s;
  logic            err_r, err_s;
  logic            fire_s;
  logic            cmd_ready_r, rsp_valid_r;
  logic            sel_r, sel_s;
  logic            wr_r, wr_s;
  logic [7:0]      addr_r, addr_s;
  logic [31:0]     dout_r, dout_s;

  assign fire_s = (state_r == IDLE) && bus.cmd_valid && cmd_ready_r;

  // Next-state, poll counter and result capture
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          state_s = WR_A;
          data_s  = 64'h0;
          err_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      WR_A:  state_s = WR_B;
      WR_B:  state_s = WR_OP;
      WR_OP: state_s = WR_GO;
      WR_GO: begin
        state_s = RD_ST;
        cnt_s   = {TO_W{1'b0}};
      end
      RD_ST: state_s = ST_W;
      ST_W: begin
        if (bus.M_din[0]) begin
          state_s = RD_LO;
        end else if (cnt_r == TO_LAST) begin
          err_s   = 1'b1;
          state_s = WR_CLR;
        end else begin
          cnt_s   = cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
          state_s = RD_ST;
        end
      end
      RD_LO: state_s = LO_W;
      LO_W: begin
        data_s[31:0] = bus.M_din;
        state_s      = RD_HI;
      end
      RD_HI: state_s = HI_W;
      HI_W: begin
        data_s[63:32] = bus.M_din;
        state_s       = WR_CLR;
      end
      WR_CLR: state_s = RSP;
      RSP: begin
        if (bus.rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RSP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Bus drive for the upcoming state; registered below so the bus is glitch-free.
  // WR_A takes A straight from the port because it is the handshake edge.
  always_comb begin
    sel_s  = 1'b1;
    wr_s   = 1'b0;
    addr_s = 8'h00;
    dout_s = 32'h0;
    case (state_s)
      IDLE, RSP:   sel_s = 1'b0;
      WR_A:        begin wr_s = 1'b1; addr_s = 8'h00; dout_s = bus.cmd_a; end
      WR_B:        begin wr_s = 1'b1; addr_s = 8'h01; dout_s = b_r; end
      WR_OP:       begin wr_s = 1'b1; addr_s = 8'h02; dout_s = {28'h0, op_r}; end
      WR_GO:       begin wr_s = 1'b1; addr_s = 8'h03; dout_s = 32'h1; end
      RD_ST, ST_W: addr_s = 8'h04;
      RD_LO, LO_W: addr_s = 8'h06;
      RD_HI, HI_W: addr_s = 8'h07;
      WR_CLR:      begin wr_s = 1'b1; addr_s = 8'h05; dout_s = 32'h1; end
      default:     sel_s = 1'b0;
    endcase
  end

  // State, captured command and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      b_r         <= 32'h0;
      op_r        <= 4'h0;
      cnt_r       <= {TO_W{1'b0}};
      data_r      <= 64'h0;
      err_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      sel_r       <= 1'b0;
      wr_r        <= 1'b0;
      addr_r      <= 8'h00;
      dout_r      <= 32'h0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      data_r      <= data_s;
      err_r       <= err_s;
      cmd_ready_r <= (state_s == IDLE);
      rsp_valid_r <= (state_s == RSP);
      sel_r       <= sel_s;
      wr_r        <= wr_s;
      addr_r      <= addr_s;
      dout_r      <= dout_s;
      if (fire_s) begin
        b_r  <= bus.cmd_b;
        op_r <= bus.cmd_op;
      end else begin
        b_r  <= b_r;
        op_r <= op_r;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = data_r;
  assign bus.rsp_err   = err_r;
  assign bus.M_sel     = sel_r;
  assign bus.M_wr      = wr_r;
  assign bus.M_addr    = addr_r;
  assign bus.M_dout    = dout_r;

endmodule

// File: doc/alu_bus_master.md
Name: alu_bus_master

Overview:
- Bus initiator that drives the slave register port of the ALU-with-multiplier from the other side.
- Accepts one operation (operand A, operand B, opcode) on a valid/ready command port and writes it into the slave. It then polls the slave's done status, reads the 64-bit result and clears the slave.
- Returns the result on a valid/ready response port.
- Sits between a sequencer/CPU-side controller and the ALUwMul slave bus.

Parameters:
- POLL_TIMEOUT, 1024, maximum number of status reads before abandoning the operation with an error.
- TO_W, 11, width of the poll counter; must hold POLL_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  master idle and able to accept a command
- cmd_a  input  32  operand A
- cmd_b  input  32  operand B
- cmd_op  input  4  ALU opcode
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  64  result {hi, lo}
- rsp_err  output  1  poll timeout occurred; qualified by rsp_valid
- M_sel  output  1  slave select
- M_wr  output  1  1 = write, 0 = read
- M_addr  output  8  slave register address
- M_dout  output  32  write data to slave
- M_din  input  32  read data from slave

Behaviour:
- Slave register map:
  - 0x00 operand A
  - 0x01 operand B
  - 0x02 opcode
  - 0x03 start (write 1)
  - 0x04 status (bit0 = done)
  - 0x05 clear (write 1)
  - 0x06 result low
  - 0x07 result high
- Slave read latency: M_din is valid in the cycle after M_addr is presented with M_sel=1, M_wr=0. The master samples M_din on the following rising edge.
- All bus outputs are registered.
- Reset values:
  - M_sel=0, M_wr=0, M_addr=0, M_dout=0
  - cmd_ready=1
  - rsp_valid=0, rsp_data=0, rsp_err=0
  - poll counter=0, state=IDLE
- Reset mid-transaction aborts immediately to these values. No clear write is issued.
- Command handshake: the command is captured on the edge where cmd_valid && cmd_ready. cmd_ready drops the next cycle and stays 0 until the response is accepted.
- FSM sequence (one bus cycle per state, M_sel=1 throughout except IDLE and RSP):
  - IDLE: wait for the command handshake.
  - WR_A: write addr 0x00, data A.
  - WR_B: write addr 0x01, data B.
  - WR_OP: write addr 0x02, data {28'b0, op}.
  - WR_GO: write addr 0x03, data 1. Poll counter is cleared here.
  - RD_ST: read addr 0x04.
  - ST_W: sample M_din.
    - If bit0=1, go to RD_LO.
    - Else, if counter == POLL_TIMEOUT-1, set err and go to WR_CLR.
    - Else, increment the counter and return to RD_ST.
  - RD_LO: read addr 0x06.
  - LO_W: capture low word.
  - RD_HI: read addr 0x07.
  - HI_W: capture high word.
  - WR_CLR: write addr 0x05, data 1.
  - RSP: M_sel=0, rsp_valid=1. Wait for rsp_ready, then go to IDLE with rsp_valid=0 and cmd_ready=1.
- Command-to-first-write latency is 1 cycle. With the slave done on the first poll, rsp_valid rises 11 cycles after the command handshake.
- On timeout: rsp_data=0, rsp_err=1. The clear write is still issued.
- rsp_err and rsp_data hold stable while rsp_valid=1 && !rsp_ready.
- rsp_valid && rsp_ready in the same cycle as a new cmd_valid: the command is not accepted until the cycle after, because cmd_ready is still 0 in RSP.
- Outside IDLE, cmd_valid is ignored.
- Opcode upper bits on M_dout are zero-extended.

Test Plan:
- Reset mid-WR_B: assert reset -> all outputs return to their reset values within the same cycle. The next command restarts from WR_A.
- Basic op: cmd A=2, B=3, op=0xC; slave model asserts done on the first poll, result 0x0000_0000_0000_0006.
  - Bus shows writes 00/2, 01/3, 02/C, 03/1, reads 04, 06, 07, then write 05/1.
  - rsp_valid 11 cycles after the handshake, rsp_data=0x6, err=0.
- Multiply latency: cmd A=2, B=3, op=0xD; slave done after 40 polls, result 0x6 -> exactly 40 status reads, then the correct response.
- Timeout: POLL_TIMEOUT=8, slave never done -> exactly 8 status reads, then the clear write. rsp_valid=1, rsp_err=1, rsp_data=0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_err stable, cmd_ready=0, no bus activity (M_sel=0).
- Back-to-back: second cmd_valid held high through the RSP handshake -> accepted the cycle after rsp_valid falls. The second result (A=2, B=3, op=0xA) is correct.
